// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one operation at a time to a combinational ALU,
// stretches MUL over several cycles, owns the NZCV flag register and
// returns results over a writeback handshake.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high. valid does not depend on ready. Once wb_valid is high,
// wb_data and wb_rd stay stable until the edge where wb_ready is high.
module alu_issue_ctrl #(
  parameter int DATA_W     = 32,
  parameter int RD_W       = 4,
  parameter int MUL_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  // request side
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              req_set_flags,
  // control
  input  logic              flush,
  input  logic              flags_load,
  input  logic [3:0]        flags_in,
  // ALU side
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  output logic              alu_c_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_c_out,
  input  logic              alu_z,
  input  logic              alu_n,
  input  logic              alu_v,
  // writeback side
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  // status
  output logic [3:0]        flags,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_TST = 4'b1000;
  localparam logic [3:0] OP_NEG = 4'b1001;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_CMN = 4'b1011;
  localparam logic [3:0] OP_MUL = 4'b1101;

  // Counter reload for MUL: counts down to zero, capture happens at zero.
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [RD_W-1:0]   rd_q, rd_d;
  logic              sf_q, sf_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic [3:0]        flags_q, flags_d;   // {N,Z,C,V}

  logic flag_only;
  logic full_flags;

  // Op classification: flag-only ops never write back; arithmetic ops
  // update all four flags, logical/shift/MUL keep C and V.
  always_comb begin
    flag_only  = (op_q == OP_TST) || (op_q == OP_CMP) || (op_q == OP_CMN);
    full_flags = (op_q == OP_ADC) || (op_q == OP_SBC) || (op_q == OP_NEG) ||
                 (op_q == OP_CMP) || (op_q == OP_CMN);
  end

  // Next-state logic; flush overrides everything and freezes all data state.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    rd_d      = rd_q;
    sf_d      = sf_q;
    cnt_d     = cnt_q;
    wb_data_d = wb_data_q;
    flags_d   = flags_q;

    case (state_q)
      S_IDLE: begin
        if (flags_load) flags_d = flags_in;
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          rd_d    = req_rd;
          sf_d    = req_set_flags;
          cnt_d   = (req_op == OP_MUL) ? MUL_LAST : 4'd0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          wb_data_d = alu_result;
          if (sf_q || flag_only) begin
            if (full_flags) flags_d = {alu_n, alu_z, alu_c_out, alu_v};
            else            flags_d = {alu_n, alu_z, flags_q[1], flags_q[0]};
          end
          state_d = flag_only ? S_IDLE : S_WB;
        end
      end
      S_WB: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d   = S_IDLE;
      op_d      = op_q;
      a_d       = a_q;
      b_d       = b_q;
      rd_d      = rd_q;
      sf_d      = sf_q;
      cnt_d     = cnt_q;
      wb_data_d = wb_data_q;
      flags_d   = flags_q;
    end
  end

  // State and data registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rd_q      <= '0;
      sf_q      <= 1'b0;
      cnt_q     <= '0;
      wb_data_q <= '0;
      flags_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      rd_q      <= rd_d;
      sf_q      <= sf_d;
      cnt_q     <= cnt_d;
      wb_data_q <= wb_data_d;
      flags_q   <= flags_d;
    end
  end

  // Outputs: ALU driven purely from latched registers; carry-in from flag C.
  always_comb begin
    alu_a     = a_q;
    alu_b     = b_q;
    alu_op    = op_q;
    alu_c_in  = flags_q[1];
    req_ready = (state_q == S_IDLE) && !flush;
    wb_valid  = (state_q == S_WB);
    wb_data   = wb_data_q;
    wb_rd     = rd_q;
    flags     = flags_q;
    busy      = (state_q != S_IDLE);
    dbg_state = state_q;
  end

endmodule
